// File: rtl/inv_mix_state_iter_if.sv
// inv_mix_state_iter_if: valid/ready bundle between the inverse round stages and the round-tail unit.
interface inv_mix_state_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_key, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_key, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_mix_state_iter.sv
// inv_mix_state_iter: AddRoundKey then InvMixColumns one column per clock through a single shared column unit.
module inv_mix_state_iter #(
    parameter int NCOL = 4
) (
    input logic clk,
    input logic rst,
    inv_mix_state_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COL, DONE} state_t;

    state_t                 state;
    logic [NCOL-1:0][31:0]  work;
    logic [NCOL-1:0][31:0]  next_work;
    logic [1:0]             col_cnt;
    logic                   bypass_q;
    logic                   out_valid_q;
    logic [127:0]           out_state_q;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 sits in the top byte, so row r lives at packed index 3-r.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [3:0][7:0] a, x2, x4, x8, m;
        a = c;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            m[3-r] = (x8[3-r] ^ x4[3-r] ^ x2[3-r])
                   ^ (x8[3-((r+1)%4)] ^ x2[3-((r+1)%4)] ^ a[3-((r+1)%4)])
                   ^ (x8[3-((r+2)%4)] ^ x4[3-((r+2)%4)] ^ a[3-((r+2)%4)])
                   ^ (x8[3-((r+3)%4)] ^ a[3-((r+3)%4)]);
        end
        return m;
    endfunction

    // Column c is the c-th 32-bit word from the top, i.e. packed index 3-c.
    always_comb begin
        next_work = work;
        next_work[~col_cnt] = inv_mix(work[~col_cnt]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            work        <= '0;
            col_cnt     <= '0;
            bypass_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    work     <= bus.in_state ^ bus.in_key;
                    bypass_q <= bus.in_bypass;
                    col_cnt  <= '0;
                    state    <= bus.in_bypass ? DONE : COL;
                end
                COL: begin
                    work    <= next_work;
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_state_q <= next_work;
                    end
                end
                DONE: begin
                    // Bypass spends one cycle in DONE publishing the keyed state.
                    if (bypass_q) begin
                        bypass_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_state_q <= work;
                    end else if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
endmodule

// File: tb/tb_inv_mix_state_iter.sv
// tb_inv_mix_state_iter: directed and random checks of the round-tail unit against a GF(2^8) reference model.
module tb_inv_mix_state_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    inv_mix_state_iter_if bus();

    inv_mix_state_iter #(.NCOL(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_2d26314c;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k, input logic byp);
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] t = s ^ k;
        logic [127:0] o = '0;
        logic [7:0] b [4];
        logic [7:0] v;
        if (byp) return t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) b[r] = t[127 - 32*c - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                v = 8'h00;
                for (int j = 0; j < 4; j++) v ^= gf_mul(coef[j], b[(r + j) % 4]);
                o[127 - 32*c - 8*r -: 8] = v;
            end
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block, waits for the result and reports latency; leaves the result in DONE.
    task automatic launch(input logic [127:0] s, input logic [127:0] k, input logic byp, output int lat);
        bus.in_valid  = 1'b1;
        bus.in_state  = s;
        bus.in_key    = k;
        bus.in_bypass = byp;
        tick();
        bus.in_valid = 1'b0;
        bus.in_state = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_accept", 128'(bus.busy), 128'(1));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after_drain", 128'(bus.in_ready), 128'(1));
        check("busy_after_drain", 128'(bus.busy), 128'(0));
    endtask

    task automatic op(input string tag, input logic [127:0] s, input logic [127:0] k, input logic byp);
        int lat;
        launch(s, k, byp, lat);
        check({tag, "_latency"}, 128'(lat), byp ? 128'(1) : 128'(4));
        check({tag, "_out"}, bus.out_state, ref_model(s, k, byp));
        drain();
    endtask

    initial begin
        logic [127:0] s, k, held, r;
        logic [127:0] q [$];
        int lat, sent, got, last;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_state = '0; bus.in_key = '0; bus.in_bypass = 1'b0; bus.out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_out_state", bus.out_state, 128'(0));
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 128'(bus.in_ready), 128'(1));

        launch(VEC_IN, '0, 1'b0, lat);
        check("vec_latency", 128'(lat), 128'(4));
        check("vec_out", bus.out_state, VEC_OUT);
        check("vec_model", ref_model(VEC_IN, '0, 1'b0), VEC_OUT);
        check("vec_in_ready_done", 128'(bus.in_ready), 128'(0));
        drain();

        launch('0, VEC_IN, 1'b0, lat);
        check("key_out", bus.out_state, VEC_OUT);
        drain();
        s = {$urandom, $urandom, $urandom, $urandom};
        op("same_key", s, s, 1'b0);
        check("same_key_zero", bus.out_state, 128'(0));

        launch(128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, lat);
        check("byp_latency", 128'(lat), 128'(1));
        check("byp_out", bus.out_state, 128'h00102030_40506070_8090a0b0_c0d0e0f0);
        drain();
        for (int i = 0; i < 3; i++)
            op("rand_byp", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int i = 0; i < 3; i++)
            op("rand_mix", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        launch(s, k, 1'b0, lat);
        held = ref_model(s, k, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("bp_valid", 128'(bus.out_valid), 128'(1));
            check("bp_state", bus.out_state, held);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_ready", 128'(bus.in_ready), 128'(1));
        check("bp_no_accept", 128'(bus.busy), 128'(0));
        check("bp_out_hold", bus.out_state, held);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        bus.in_valid = 1'b1; bus.in_state = VEC_IN; bus.in_key = '0; bus.in_bypass = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_out_state", bus.out_state, 128'(0));
        check("mid_rst_busy", 128'(bus.busy), 128'(0));
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        op("post_rst_vec", VEC_IN, '0, 1'b0);
        check("post_rst_vec_const", bus.out_state, VEC_OUT);

        sent = 0; got = 0; last = 0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            if (bus.in_ready) begin
                if (sent < 8) begin
                    s = {$urandom, $urandom, $urandom, $urandom};
                    k = {$urandom, $urandom, $urandom, $urandom};
                    bus.in_state = s; bus.in_key = k; bus.in_bypass = 1'b0;
                    q.push_back(ref_model(s, k, 1'b0));
                    sent++;
                end else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                r = (q.size() > 0) ? q.pop_front() : 128'hx;
                check("stream_out", bus.out_state, r);
                if (got > 0) check("stream_spacing", 128'(cyc - last), 128'(6));
                last = cyc;
                got++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_count", 128'(got), 128'(8));
        check("stream_leftover", 128'(q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_mix_state_iter.md
Name: inv_mix_state_iter

Overview:
Iterative decrypt-side round-tail unit for the AES datapath. It accepts a 128-bit state and round key, performs AddRoundKey, then applies InvMixColumns one 32-bit column per clock. The result is delivered over a valid/ready handshake. It sits between the InvSubBytes/InvShiftRows stage and the next inverse round, and trades a single shared column unit for 4-cycle latency.

Parameters:
- NCOL, 4, number of columns per state; fixed for AES-128, and the column counter is 2 bits wide.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream offers in_state/in_key/in_bypass.
- in_ready  output  1  block can accept a new state.
- in_state  input  128  state; column c = in_state[127-32c -: 32], row 0 byte in MSBs of each column.
- in_key  input  128  round key, same byte layout.
- in_bypass  input  1  1 = final decrypt round: AddRoundKey only, no InvMixColumns.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts result.
- out_state  output  128  result, same byte layout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE; work register, column counter and bypass flag clear to 0.
  - out_valid=0, out_state=0, busy=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after rst deasserts.
- FSM states: IDLE, COL, DONE.
- IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid=1: work <= in_state ^ in_key; bypass_q <= in_bypass; col_cnt <= 0.
  - Next state is DONE if in_bypass=1, else COL.
- COL:
  - in_ready=0.
  - Each edge replaces column col_cnt of work with InvMixColumns of that column: out row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3], indices mod 4.
  - Arithmetic is GF(2^8) with reduction polynomial 0x11B; multiply by 02 is a left shift, XOR 0x1B when bit 7 was set.
  - col_cnt increments and wraps 3->0. The edge that processes col_cnt=3 moves the FSM to DONE.
- DONE:
  - out_valid=1 and out_state=work; both are stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - out_state keeps its last value until the next result, or until reset.
- Latency, counting the accept edge as E0:
  - Normal: out_valid rises after E4.
  - Bypass: out_valid rises after E1.
- Throughput with out_ready held high:
  - Normal: one block per 6 cycles.
  - Bypass: one block per 3 cycles.
- in_valid is ignored outside IDLE. Held inputs are not sampled again until the FSM returns to IDLE. in_state/in_key need only be valid on the accept edge.
- Simultaneous events:
  - DONE with out_ready=1 and in_valid=1 does not accept; the new state is accepted no earlier than the following edge in IDLE.
  - rst overrides every other input.
- Only one column unit exists; the column is selected by col_cnt.

Test Plan:
- Column vectors: in_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, key=0, bypass=0 -> out_state=db135345_f20a225c_01010101_2d26314c; out_valid rises exactly 4 edges after accept; busy high from E0 until DONE is exited.
- Key path: in_state=0, in_key=8e4da1bc_9fdc589d_01010101_4d7ebdf8, bypass=0 -> same output as the column-vector scenario. in_state=in_key=any value -> out_state=0.
- Bypass: in_state=00112233_44556677_8899aabb_ccddeeff, in_key=000102030405060708090a0b0c0d0e0f, bypass=1 -> out_state=00102030_40506070_8090a0b0_c0d0e0f0, out_valid after E1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state -> out_valid=1, out_state unchanged, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-op: assert rst asynchronously (between edges) while col_cnt=2 -> out_valid, out_state and busy go to 0 immediately. After release, a fresh op with the column vectors gives the correct result.
- Streaming: 8 back-to-back blocks, in_valid and out_ready held high, random keys, normal mode -> results match the reference model in order, one per 6 cycles, no drops or duplicates.
